// File: rtl/perf_event_unit.sv
// ============================================================================
// Module      : perf_event_unit
// Description : Saturating commit/cache event counters with halt-drain freeze
//               and a registered 16-bit read port with atomic upper-half shadow.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module perf_event_unit #(
   parameter int CNT_W     = 32,
   parameter int DRAIN_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ev_retire,
   input  logic        ev_ireq,
   input  logic        ev_ihit,
   input  logic        ev_dreq,
   input  logic        ev_dhit,
   input  logic        halt,
   input  logic        clr,
   input  logic        rd_req,
   input  logic [2:0]  rd_sel,
   input  logic        rd_hi,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        frozen,
   output logic        err
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_FROZEN = 2'd2;

   localparam int             DC_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DC_W-1:0] DC_LOAD = (DRAIN_CYC > 0) ? DC_W'(DRAIN_CYC - 1) : '0;

   logic [1:0]       state_q, state_d;
   logic [DC_W-1:0]  dc_q, dc_d;
   logic             count_en, frozen_w;

   logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, ireq_q, ireq_d;
   logic [CNT_W-1:0] ihit_q, ihit_d, dreq_q, dreq_d, dhit_q, dhit_d;
   logic [CNT_W-1:0] sel_cnt;
   logic [15:0]      upper_w;
   logic [15:0]      rd_data_q, rd_data_d, shadow_q, shadow_d;
   logic [2:0]       sh_sel_q, sh_sel_d;
   logic             sh_vld_q, sh_vld_d, rd_valid_q, rd_valid_d, err_q, err_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
      return (ev && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RUN;
         dc_q    <= '0;
      end else begin
         state_q <= state_d;
         dc_q    <= dc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      if (clr) begin
         state_d = ST_RUN;
         dc_d    = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (halt) begin
                  if (DRAIN_CYC == 0) begin
                     state_d = ST_FROZEN;
                  end else begin
                     state_d = ST_DRAIN;
                     dc_d    = DC_LOAD;
                  end
               end
            end
            ST_DRAIN: begin
               if (dc_q == '0) state_d = ST_FROZEN;
               else            dc_d    = dc_q - DC_W'(1);
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      count_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      frozen_w = (state_q == ST_FROZEN);
   end

   always_comb begin
      cyc_d  = cyc_q;
      ret_d  = ret_q;
      ireq_d = ireq_q;
      ihit_d = ihit_q;
      dreq_d = dreq_q;
      dhit_d = dhit_q;
      if (clr) begin
         cyc_d  = '0;
         ret_d  = '0;
         ireq_d = '0;
         ihit_d = '0;
         dreq_d = '0;
         dhit_d = '0;
      end else if (count_en) begin
         cyc_d  = sat_inc(cyc_q, 1'b1);
         ret_d  = sat_inc(ret_q, ev_retire);
         ireq_d = sat_inc(ireq_q, ev_ireq);
         ihit_d = sat_inc(ihit_q, ev_ihit);
         dreq_d = sat_inc(dreq_q, ev_dreq);
         dhit_d = sat_inc(dhit_q, ev_dhit);
      end
      // Orphan hits are still counted above; err just records that they happened.
      err_d = clr ? 1'b0 : (err_q | (ev_ihit & ~ev_ireq) | (ev_dhit & ~ev_dreq));
   end

   always_comb begin
      case (rd_sel)
         3'd0:    sel_cnt = cyc_q;
         3'd1:    sel_cnt = ret_q;
         3'd2:    sel_cnt = ireq_q;
         3'd3:    sel_cnt = ihit_q;
         3'd4:    sel_cnt = dreq_q;
         3'd5:    sel_cnt = dhit_q;
         default: sel_cnt = '0;
      endcase
      upper_w = 16'(sel_cnt[CNT_W-1:16]);
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_req;
      shadow_d   = shadow_q;
      sh_sel_d   = sh_sel_q;
      sh_vld_d   = sh_vld_q;
      if (rd_req) begin
         if (rd_sel == 3'd6) begin
            rd_data_d = {12'b0, err_q, frozen_w, state_q};
         end else if (rd_sel == 3'd7) begin
            rd_data_d = '0;
         end else if (!rd_hi) begin
            // Capture the upper half now so a following hi read is coherent.
            rd_data_d = sel_cnt[15:0];
            shadow_d  = upper_w;
            sh_sel_d  = rd_sel;
            sh_vld_d  = 1'b1;
         end else begin
            rd_data_d = (sh_vld_q && (sh_sel_q == rd_sel)) ? shadow_q : upper_w;
         end
      end
      if (clr) begin
         shadow_d = '0;
         sh_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc_q      <= '0;
         ret_q      <= '0;
         ireq_q     <= '0;
         ihit_q     <= '0;
         dreq_q     <= '0;
         dhit_q     <= '0;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         shadow_q   <= '0;
         sh_sel_q   <= '0;
         sh_vld_q   <= 1'b0;
      end else begin
         cyc_q      <= cyc_d;
         ret_q      <= ret_d;
         ireq_q     <= ireq_d;
         ihit_q     <= ihit_d;
         dreq_q     <= dreq_d;
         dhit_q     <= dhit_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         shadow_q   <= shadow_d;
         sh_sel_q   <= sh_sel_d;
         sh_vld_q   <= sh_vld_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign frozen   = frozen_w;
   assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_perf_event_unit.sv
// ============================================================================
// Module      : tb_perf_event_unit
// Description : Directed scoreboard bench for perf_event_unit (32-bit/drain-4
//               and 17-bit/drain-0 instances).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_perf_event_unit;

   logic        clk = 1'b0;
   logic        rst, ev_retire, ev_ireq, ev_ihit, ev_dreq, ev_dhit;
   logic        halt, halt2, clr, rd_req, rd_hi;
   logic [2:0]  rd_sel;
   logic [15:0] rd_data, rd_data2;
   logic        rd_valid, rd_valid2, frozen, frozen2, err, err2;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] sb [$];

   always #5 clk = ~clk;

   perf_event_unit #(.CNT_W(32), .DRAIN_CYC(4)) dut (
      .clk(clk), .rst(rst), .ev_retire(ev_retire), .ev_ireq(ev_ireq), .ev_ihit(ev_ihit),
      .ev_dreq(ev_dreq), .ev_dhit(ev_dhit), .halt(halt), .clr(clr), .rd_req(rd_req),
      .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data), .rd_valid(rd_valid),
      .frozen(frozen), .err(err)
   );

   perf_event_unit #(.CNT_W(17), .DRAIN_CYC(0)) dut2 (
      .clk(clk), .rst(rst), .ev_retire(ev_retire), .ev_ireq(ev_ireq), .ev_ihit(ev_ihit),
      .ev_dreq(ev_dreq), .ev_dhit(ev_dhit), .halt(halt2), .clr(clr), .rd_req(rd_req),
      .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data2), .rd_valid(rd_valid2),
      .frozen(frozen2), .err(err2)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   // One read transaction; expected word goes on the scoreboard at issue time.
   task automatic rd(input int which, input logic [2:0] sel, input logic hi,
                     input logic [15:0] exp, input logic with_clr, input string tag);
      logic [15:0] e;
      @(negedge clk);
      rd_req = 1'b1;
      rd_sel = sel;
      rd_hi  = hi;
      clr    = with_clr;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, 16'((which == 2) ? rd_valid2 : rd_valid), 16'h0001);
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
      end else begin
         e = sb.pop_front();
         chk(tag, (which == 2) ? rd_data2 : rd_data, e);
      end
      @(negedge clk);
      rd_req = 1'b0;
      clr    = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_vdrop"}, 16'((which == 2) ? rd_valid2 : rd_valid), 16'h0000);
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; ev_retire = 1'b0; ev_ireq = 1'b0; ev_ihit = 1'b0;
      ev_dreq = 1'b0; ev_dhit = 1'b0; halt = 1'b0; halt2 = 1'b0;
      clr = 1'b0; rd_req = 1'b0; rd_sel = 3'd0; rd_hi = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid",  16'(rd_valid), 16'h0000);
      chk("rst_data",   rd_data,       16'h0000);
      chk("rst_frozen", 16'(frozen),   16'h0000);
      chk("rst_err",    16'(err),      16'h0000);

      // Idle cycle count
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(posedge clk);
      rd(1, 3'd0, 1'b0, 16'h000A, 1'b0, "idle_cyc");
      rd(1, 3'd1, 1'b0, 16'h0000, 1'b0, "idle_ret");

      // 17-bit saturation and shadow on the narrow instance
      @(negedge clk);
      force dut2.cyc_q = 17'h1FFFC;
      #1;
      release dut2.cyc_q;
      repeat (5) @(posedge clk);
      rd(2, 3'd0, 1'b0, 16'hFFFF, 1'b0, "sat_lo");
      rd(2, 3'd0, 1'b1, 16'h0001, 1'b0, "sat_hi_shadow");
      rd(2, 3'd1, 1'b0, 16'h0000, 1'b0, "sat_ret");
      rd(2, 3'd0, 1'b1, 16'h0001, 1'b0, "sat_hi_live");
      @(negedge clk);
      halt2 = 1'b1;
      @(posedge clk);
      #1;
      chk("drain0_frozen", 16'(frozen2), 16'h0001);
      @(negedge clk);
      halt2 = 1'b0;

      // Retire count, halt drain and freeze
      clear_pulse();
      ev_retire = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      ev_retire = 1'b0;
      halt      = 1'b1;
      @(posedge clk);
      #1;
      chk("halt_frozen0", 16'(frozen), 16'h0000);
      @(negedge clk);
      halt = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("drain_frozen%0d", i), 16'(frozen), (i == 4) ? 16'h0001 : 16'h0000);
      end
      rd(1, 3'd1, 1'b0, 16'h0007, 1'b0, "frz_ret");
      rd(1, 3'd0, 1'b0, 16'h000C, 1'b0, "frz_cyc");
      rd(1, 3'd6, 1'b0, 16'h0006, 1'b0, "frz_status");
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      rd(1, 3'd6, 1'b1, 16'h0006, 1'b0, "frz_halt_ignored");
      rd(1, 3'd7, 1'b0, 16'h0000, 1'b0, "sel7_zero");

      // Orphan D-cache hit sets sticky err; clr clears everything
      clear_pulse();
      ev_dhit = 1'b1;
      @(posedge clk);
      #1;
      chk("err_set", 16'(err), 16'h0001);
      @(negedge clk);
      ev_dhit = 1'b0;
      rd(1, 3'd5, 1'b0, 16'h0001, 1'b0, "err_dhit");
      rd(1, 3'd6, 1'b0, 16'h0008, 1'b0, "err_status");
      rd(1, 3'd6, 1'b0, 16'h0008, 1'b1, "clr_preclear");
      chk("err_cleared", 16'(err), 16'h0000);
      rd(1, 3'd5, 1'b0, 16'h0000, 1'b0, "clr_dhit");
      rd(1, 3'd6, 1'b0, 16'h0000, 1'b0, "clr_status");

      // Atomic read across the 0x20000 boundary
      @(negedge clk);
      force dut.cyc_q = 32'h0001_FFFE;
      #1;
      release dut.cyc_q;
      rd(1, 3'd0, 1'b0, 16'hFFFF, 1'b0, "atom_lo");
      rd(1, 3'd0, 1'b1, 16'h0001, 1'b0, "atom_hi_shadow");
      rd(1, 3'd1, 1'b0, 16'h0000, 1'b0, "atom_ret");
      rd(1, 3'd0, 1'b1, 16'h0002, 1'b0, "atom_hi_live");

      // Reset in the middle of DRAIN with a read pending
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      rd(1, 3'd6, 1'b0, 16'h0001, 1'b0, "drain_status");
      @(negedge clk);
      rst    = 1'b0;
      rd_req = 1'b1;
      rd_sel = 3'd0;
      rd_hi  = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_valid",  16'(rd_valid), 16'h0000);
      chk("mrst_frozen", 16'(frozen),   16'h0000);
      chk("mrst_data",   rd_data,       16'h0000);
      @(negedge clk);
      rst    = 1'b1;
      rd_req = 1'b0;
      rd(1, 3'd0, 1'b0, 16'h0001, 1'b0, "mrst_cyc");
      rd(1, 3'd1, 1'b0, 16'h0000, 1'b0, "mrst_ret");
      chk("mrst_nofreeze", 16'(frozen), 16'h0000);
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      rd(1, 3'd6, 1'b0, 16'h0001, 1'b0, "redrain_status");
      chk("err2_clean", 16'(err2), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
